// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: instruction-memory request/response bus.
// master is the fetch unit, slave is the instruction memory.
`ifndef IM_ADDR_LEN
`define IM_ADDR_LEN 32
`endif
`ifndef IM_DATA_LEN
`define IM_DATA_LEN 32
`endif

interface ifu_fetch_if;
  logic                    imem_req;
  logic [`IM_ADDR_LEN-1:0] imem_addr;
  logic                    imem_ready;
  logic                    imem_rvalid;
  logic [`IM_DATA_LEN-1:0] imem_rdata;
  logic                    imem_rerr;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata,
    input  imem_rerr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata,
    output imem_rerr
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: in-order word fetch, credit-limited issue, instruction FIFO.
// Optional IFU_BYPASS_EN forwards a response to decode when the FIFO is empty.
`ifndef IM_ADDR_LEN
`define IM_ADDR_LEN 32
`endif
`ifndef IM_DATA_LEN
`define IM_DATA_LEN 32
`endif

module ifu_fetch #(
  parameter logic [`IM_ADDR_LEN-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_OUT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect,
  input  logic [`IM_ADDR_LEN-1:0] redirect_pc,
  input  logic                    stall,
  ifu_fetch_if.master             imem,
  output logic [`IM_DATA_LEN-1:0] inst,
  output logic                    inst_valid,
  output logic [`IM_ADDR_LEN-1:0] pc,
  output logic                    inst_err
);
  localparam int AL = `IM_ADDR_LEN;
  localparam int DL = `IM_DATA_LEN;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int SW = $clog2(FIFO_DEPTH + 2 * MAX_OUT + 1) + 1;

  logic [AL-1:0] fetch_pc_q, fetch_pc_d;
  logic [AL-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [OW-1:0] kill_cnt_q, kill_cnt_d;
  logic          halted_q, halted_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DL-1:0] inst_mem_q [FIFO_DEPTH];
  logic [AL-1:0] pc_mem_q   [FIFO_DEPTH];
  logic          err_mem_q  [FIFO_DEPTH];

  logic          head_valid;
  logic          credit_ok;
  logic          req;
  logic          accept;
  logic          kill;
  logic          good;
  logic          bypass;
  logic          push;
  logic          pop;
  logic [AL-1:0] redir_al;

  always_comb begin
    head_valid = cnt_q != '0;
    // space for everything in flight that will actually land
    credit_ok  = (SW'(out_cnt_q) + SW'(cnt_q))
               < (SW'(FIFO_DEPTH) + SW'(kill_cnt_q));
    req        = ~rst & ~redirect & ~halted_q
               & (out_cnt_q < OW'(MAX_OUT)) & credit_ok;
    accept     = req & imem.imem_ready;
    kill       = imem.imem_rvalid
               & ((kill_cnt_q != '0) | redirect);
    good       = imem.imem_rvalid & ~kill;
`ifdef IFU_BYPASS_EN
    bypass     = good & ~head_valid & ~stall;
`else
    bypass     = 1'b0;
`endif
    push       = good & ~bypass;
    pop        = head_valid & ~stall & ~redirect;
    redir_al   = {redirect_pc[AL-1:2], 2'b00};

    out_cnt_d  = out_cnt_q + OW'(accept)
               - OW'(imem.imem_rvalid);
    kill_cnt_d = kill_cnt_q;
    if (imem.imem_rvalid && kill_cnt_q != '0)
      kill_cnt_d = kill_cnt_q - OW'(1);
    fetch_pc_d = accept ? fetch_pc_q + AL'(4)
                        : fetch_pc_q;
    resp_pc_d  = good ? resp_pc_q + AL'(4)
                      : resp_pc_q;
    halted_d   = halted_q;
    // a fault stops fetch; whatever is still in flight is junk
    if (good && imem.imem_rerr) begin
      halted_d   = 1'b1;
      kill_cnt_d = out_cnt_d;
    end
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    if (redirect) begin
      fetch_pc_d = redir_al;
      resp_pc_d  = redir_al;
      halted_d   = 1'b0;
      kill_cnt_d = out_cnt_d;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
    end

    imem.imem_req  = req;
    imem.imem_addr = rst ? {RESET_PC[AL-1:2], 2'b00}
                         : {fetch_pc_q[AL-1:2], 2'b00};

    inst       = '0;
    pc         = '0;
    inst_err   = 1'b0;
    inst_valid = head_valid | bypass;
    if (bypass) begin
      inst     = imem.imem_rdata;
      pc       = resp_pc_q;
      inst_err = imem.imem_rerr;
    end else if (head_valid) begin
      inst     = inst_mem_q[rd_ptr_q];
      pc       = pc_mem_q[rd_ptr_q];
      inst_err = err_mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      kill_cnt_q <= '0;
      halted_q   <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      kill_cnt_q <= kill_cnt_d;
      halted_q   <= halted_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !redirect) begin
      inst_mem_q[wr_ptr_q] <= imem.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
      err_mem_q[wr_ptr_q]  <= imem.imem_rerr;
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized fetch traffic against a stream-level model.
// Checks issue rule, addresses, delivered pc/inst/err order and flushes.
module tb_ifu_fetch;
  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] WRPC = 32'hFFFF_FFFC;

  typedef struct {
    logic [31:0] addr;
    int          ep;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
  } got_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        inst_err;

  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_stall = 1'b0;
  logic [31:0] w_inst;
  logic        w_inst_valid;
  logic [31:0] w_pc;
  logic        w_inst_err;

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  ent_t        mq[$];
  got_t        pcq[$];
  int          epoch;
  bit          halted;
  logic [31:0] exp_fetch;
  logic [31:0] err_addr;

  bit          want_first;
  logic [31:0] first_pc;
  logic [31:0] err_pc;
  logic [31:0] last_pc;
  logic [31:0] last_addr;
  logic        last_req;
  logic        w_req;
  logic [31:0] w_addr;
  int          vcnt;

  ifu_fetch_if bus ();
  ifu_fetch_if bus2 ();

  always #5 clk = ~clk;

  ifu_fetch #(
    .RESET_PC(RPC), .FIFO_DEPTH(4), .MAX_OUT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .imem(bus.master),
    .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .inst_err(inst_err)
  );

  ifu_fetch #(
    .RESET_PC(WRPC), .FIFO_DEPTH(4), .MAX_OUT(2)
  ) dut_w (
    .clk(clk), .rst(rst),
    .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .stall(w_stall), .imem(bus2.master),
    .inst(w_inst), .inst_valid(w_inst_valid),
    .pc(w_pc), .inst_err(w_inst_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    if (o !== e) begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  initial begin
    #1000000;
    if (!done) begin
      bad++;
      $error("FAIL timeout: test did not finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  task automatic model_reset();
    mq.delete();
    pcq.delete();
    epoch      = 0;
    halted     = 0;
    exp_fetch  = RPC;
    want_first = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    bus.imem_ready  = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rerr   = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    @(negedge clk);
    #1;
    chk("rst_req2", bus.imem_req, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", inst_err, 1'b0);
    chk("rst_addr", bus.imem_addr, RPC);
    chk("rst_waddr", bus2.imem_addr, WRPC);
    model_reset();
  endtask

  task automatic step(input bit st, input bit rd,
                      input logic [31:0] rpc,
                      input bit rdy, input bit rv);
    bit   resp;
    bit   exp_req;
    bit   good;
    bit   req_s;
    bit   val_s;
    ent_t e;
    int   stale;
    @(negedge clk);
    rst            = 1'b0;
    stall          = st;
    redirect       = rd;
    redirect_pc    = rpc;
    bus.imem_ready = rdy;
    resp           = rv && (mq.size() != 0);
    bus.imem_rvalid = resp;
    bus.imem_rdata  = resp ? fdat(mq[0].addr) : 32'h0;
    bus.imem_rerr   = resp && (mq[0].addr == err_addr);
    #1;
    stale = 0;
    foreach (mq[i]) if (mq[i].ep != epoch) stale++;
    exp_req = !rd && !halted && (mq.size() < 2)
           && (mq.size() + pcq.size() < 4 + stale);
    chk("req", bus.imem_req, exp_req);
    if (exp_req) chk("addr", bus.imem_addr, exp_fetch);
    chk("valid", inst_valid, pcq.size() != 0);
    if (pcq.size() != 0) begin
      chk("pc", pc, pcq[0].addr);
      chk("inst", inst, fdat(pcq[0].addr));
      chk("ierr", inst_err, pcq[0].err);
    end
    req_s     = bus.imem_req;
    val_s     = inst_valid;
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;
    last_pc   = pc;
    w_req     = bus2.imem_req;
    w_addr    = bus2.imem_addr;
    if (val_s) vcnt++;
    if (val_s && inst_err) err_pc = pc;
    if (rd) want_first = 1;
    else if (want_first && val_s) begin
      first_pc   = pc;
      want_first = 0;
    end
    @(posedge clk);
    if (val_s && !st && !rd) void'(pcq.pop_front());
    good = 0;
    if (resp) begin
      e    = mq.pop_front();
      good = !rd && (e.ep == epoch);
      if (good) pcq.push_back('{e.addr, e.addr == err_addr});
    end
    if (req_s && rdy) begin
      mq.push_back('{exp_fetch, epoch});
      exp_fetch = exp_fetch + 32'd4;
    end
    if (good && e.addr == err_addr) begin
      halted = 1;
      epoch++;
    end
    if (rd) begin
      pcq.delete();
      epoch++;
      halted    = 0;
      exp_fetch = {rpc[31:2], 2'b00};
    end
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] tgt;
    bus2.imem_ready  = 1'b1;
    bus2.imem_rvalid = 1'b0;
    bus2.imem_rdata  = 32'h0;
    bus2.imem_rerr   = 1'b0;
    bus.imem_rdata   = 32'h0;
    redirect_pc      = 32'h0;
    err_addr         = 32'h1;
    rst              = 1'b1;
    do_reset();

    step(0, 0, 0, 1, 1);
    chk("wrap_req", w_req, 1'b1);
    chk("wrap_a0", w_addr, WRPC);
    step(0, 0, 0, 1, 1);
    chk("wrap_a1", w_addr, 32'h0);

    vcnt = 0;
    for (int i = 2; i < 20; i++) step(0, 0, 0, 1, 1);
    chk("stream_cont", vcnt, 18);

    step(1, 0, 0, 1, 1);
    hold_pc = last_pc;
    for (int i = 1; i < 10; i++) step(1, 0, 0, 1, 1);
    chk("bp_hold", last_pc, hold_pc);
    chk("bp_noreq", last_req, 1'b0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("two_out", mq.size(), 2);
    step(0, 1, 32'h2002, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("redir_addr", last_addr, 32'h2000);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);
    chk("redir_first", first_pc, 32'h2000);

    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    step(0, 1, 32'h3000, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);
    chk("rvr_first", first_pc, 32'h3000);

    err_addr = 32'h10C;
    err_pc   = 32'h0;
    step(0, 1, 32'h104, 1, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 1);
    chk("ferr_first", first_pc, 32'h104);
    chk("ferr_pc", err_pc, 32'h10C);
    chk("ferr_halt", last_req, 1'b0);
    err_addr = 32'h1;
    step(0, 1, 32'hFFFF_FFF8, 1, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

    for (int i = 0; i < 2500; i++) begin
      bit rd;
      rd  = ($urandom_range(0, 99) < 5);
      tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                        : $urandom;
      if (rd) begin
        if ($urandom_range(0, 1) == 1)
          err_addr = {tgt[31:2], 2'b00}
                   + 32'd4 * $urandom_range(0, 6);
        else
          err_addr = 32'h1;
      end
      step($urandom_range(0, 99) < 30, rd, tgt,
           $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 60);
      if (i == 1200) do_reset();
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 1);

    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
